// File: rtl/t_toggle_counter_ctrl.sv
// rtl/t_toggle_counter_ctrl.sv - IDLE/RUN/PAUSE/DONE sequencer driving a WIDTH-bit T flip-flop up/down counter bank
// Optional build macro: TTOG_AUTORELOAD_EN (DONE reloads q from load_val and re-enters RUN)

module t_toggle_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_cnt,
    input  logic             dir,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] up_mask;
    logic [WIDTH-1:0] dn_mask;
    logic             term_hit;
    logic             count_step;
    logic             at_wrap_edge;
    logic             do_load;
    logic [WIDTH-1:0] q_nxt;

    // Toggle masks: bit i flips when every lower bit is 1 (up) or 0 (down)
    assign up_mask[0] = 1'b1;
    assign dn_mask[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_mask
        assign up_mask[i] = &q[i-1:0];
        assign dn_mask[i] = &(~q[i-1:0]);
    end

    assign term_hit   = (q == term_cnt);
    // A count step is taken only in RUN when nothing of higher priority fires
    assign count_step = (state == ST_RUN) && !stop && !term_hit && !pause;
    assign t_vec      = count_step ? (dir ? up_mask : dn_mask) : '0;

    // Crossing the modulus boundary in the direction of travel
    assign at_wrap_edge = count_step && (dir ? (&q) : (q == '0));

    // Preload is accepted in IDLE and PAUSE unless an abort wins
    assign do_load = load && ((state == ST_IDLE) || ((state == ST_PAUSE) && !stop));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection with stop > terminal > pause > count priority
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (term_hit) begin
                    state_nxt = ST_DONE;
                end else if (pause) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
`ifdef TTOG_AUTORELOAD_EN
                state_nxt = stop ? ST_IDLE : ST_RUN;
`else
                state_nxt = ST_IDLE;
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next bank value: preload/reload overrides the toggle update
    always_comb begin
        q_nxt = q ^ t_vec;
        if (do_load) begin
            q_nxt = load_val;
        end
`ifdef TTOG_AUTORELOAD_EN
        if ((state == ST_DONE) && !stop) begin
            q_nxt = load_val;
        end
`endif
    end

    // T flip-flop bank and registered wrap pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_nxt;
            wrap <= at_wrap_edge;
        end
    end

    // Status outputs decoded from the current state
    always_comb begin
        done = (state == ST_DONE);
`ifdef TTOG_AUTORELOAD_EN
        busy = (state == ST_RUN) || (state == ST_PAUSE) || (state == ST_DONE);
`else
        busy = (state == ST_RUN) || (state == ST_PAUSE);
`endif
    end

endmodule
